// File: rtl/dense_layer.sv
// dense_layer: single fully-connected neuron over the flattened layer-2 map.
// Streams N feature/weight pairs through a capture -> multiply -> accumulate
// pipeline, then adds bias, rounds to Q4.16, saturates, optionally applies
// ReLU and emits one result with a valid pulse.
module dense_layer #(
    parameter int                  N       = 2048,
    parameter logic signed [39:0]  BIAS    = 40'sh0,
    parameter bit                  RELU_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_crd,
    output logic [11:0] o_caddr_rd,
    output logic [2:0]  o_csel,
    input  logic [19:0] i_cdata_rd,
    output logic [11:0] o_waddr,
    input  logic [19:0] i_wdata,
    output logic        o_valid,
    output logic [19:0] o_data
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_FETCH = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [1:0]  S_FINAL = 2'd3;
    localparam logic [11:0] LAST    = 12'(N - 1);
    localparam logic [2:0]  CSEL_L2 = 3'b101;

    logic [1:0]          state;
    logic                drain_cnt;
    // vld_pipe[0]: read data on the input bus, [1]: capture regs hold data,
    // [2]: product reg holds a product to accumulate
    logic [2:0]          vld_pipe;
    logic signed [19:0]  feat_q;
    logic signed [19:0]  wt_q;
    logic signed [39:0]  prod_q;
    logic signed [51:0]  acc_q;

    logic signed [51:0]  acc_fin;
    logic signed [51:0]  sum;
    logic signed [52:0]  rnd;
    logic signed [36:0]  r;
    logic [19:0]         res;

    // Final result: the last product retires in the FINAL cycle itself, so it
    // is folded in here rather than waiting one more cycle for the accumulator.
    always_comb begin
        acc_fin = acc_q + (vld_pipe[2] ? {{12{prod_q[39]}}, prod_q} : 52'd0);
        sum     = acc_fin + {{12{BIAS[39]}}, BIAS};
        // round half up: floor((sum + 2^15) / 2^16)
        rnd     = {sum[51], sum} + 53'sd32768;
        r       = 37'(rnd >>> 16);
        if (r > 37'sd524287)
            res = 20'h7FFFF;
        else if (r < -37'sd524288)
            res = 20'h80000;
        else
            res = r[19:0];
        if (RELU_EN && res[19])
            res = 20'h00000;
    end

    // Control FSM: address generation, busy/strobe outputs, result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            drain_cnt  <= 1'b0;
            o_busy     <= 1'b0;
            o_crd      <= 1'b0;
            o_csel     <= 3'b000;
            o_caddr_rd <= 12'd0;
            o_waddr    <= 12'd0;
            o_valid    <= 1'b0;
            o_data     <= 20'd0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_FETCH;
                        o_busy     <= 1'b1;
                        o_crd      <= 1'b1;
                        o_csel     <= CSEL_L2;
                        o_caddr_rd <= 12'd0;
                        o_waddr    <= 12'd0;
                    end
                end
                S_FETCH: begin
                    if (o_caddr_rd == LAST) begin
                        state     <= S_DRAIN;
                        o_crd     <= 1'b0;
                        o_csel    <= 3'b000;
                        drain_cnt <= 1'b0;
                    end else begin
                        o_caddr_rd <= o_caddr_rd + 12'd1;
                        o_waddr    <= o_caddr_rd + 12'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt)
                        state <= S_FINAL;
                    else
                        drain_cnt <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b1;
                    o_data  <= res;
                end
            endcase
        end
    end

    // Datapath: capture read data, register product, accumulate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= 3'b000;
            feat_q   <= 20'sd0;
            wt_q     <= 20'sd0;
            prod_q   <= 40'sd0;
            acc_q    <= 52'sd0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], o_crd};
            if (vld_pipe[0]) begin
                feat_q <= i_cdata_rd;
                wt_q   <= i_wdata;
            end
            if (vld_pipe[1])
                prod_q <= feat_q * wt_q;
            if (state == S_IDLE && i_start)
                acc_q <= 52'sd0;
            else if (vld_pipe[2])
                acc_q <= acc_q + {{12{prod_q[39]}}, prod_q};
        end
    end

endmodule
